// File: rtl/csr_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : csr_job_sequencer
// Purpose  : Runs one job at a time on a CSR-mapped processing engine:
//            programs CONFIG/DATA_IN, starts the engine, polls STATUS, reads
//            DATA_OUT (or recovers the engine on ERR/timeout) and returns a
//            result over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module csr_job_sequencer #(
  parameter int POLL_LIMIT = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  // job intake
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_data,
  input  logic [7:0]  job_count,
  // result return
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_status,
  output logic        busy,
  // engine CSR port
  output logic [7:0]  csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_wr_en,
  output logic        csr_rd_en,
  input  logic [31:0] csr_rdata,
  input  logic        csr_ready
);

  localparam int              c_cnt_w      = $clog2(POLL_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_poll_limit = c_cnt_w'(POLL_LIMIT);

  localparam logic [7:0] c_addr_ctrl   = 8'h00;
  localparam logic [7:0] c_addr_status = 8'h04;
  localparam logic [7:0] c_addr_config = 8'h08;
  localparam logic [7:0] c_addr_din    = 8'h0C;
  localparam logic [7:0] c_addr_dout   = 8'h10;

  localparam logic [1:0] c_res_ok      = 2'b00;
  localparam logic [1:0] c_res_err     = 2'b01;
  localparam logic [1:0] c_res_timeout = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_CFG   = 4'd1,
    S_WR_DIN   = 4'd2,
    S_WR_START = 4'd3,
    S_POLL     = 4'd4,
    S_RD_OUT   = 4'd5,
    S_RCV_CTRL = 4'd6,
    S_RCV_STS  = 4'd7,
    S_RESP     = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [31:0]        r_job_data;
  logic [7:0]         r_job_count;
  logic [c_cnt_w-1:0] r_poll_cnt;
  logic               r_seen_busy;
  logic [31:0]        r_last_status;
  logic [31:0]        r_res_data;
  logic [1:0]         r_res_status;

  logic [c_cnt_w-1:0] w_poll_inc;
  logic               w_poll_err;
  logic               w_poll_done;
  logic               w_poll_timeout;

  // Classify the STATUS word returned by the current poll read.
  // ERR wins over DONE, DONE wins over timeout; a DONE is only trusted once
  // an earlier read of this job has shown BUSY (otherwise it is stale).
  assign w_poll_inc     = r_poll_cnt + c_cnt_w'(1);
  assign w_poll_err     = csr_rdata[2];
  assign w_poll_done    = !csr_rdata[2] && !csr_rdata[1] && csr_rdata[0] && r_seen_busy;
  assign w_poll_timeout = !w_poll_err && !w_poll_done && (w_poll_inc == c_poll_limit);

  assign res_data   = r_res_data;
  assign res_status = r_res_status;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; CSR outputs depend only on state and latches.
  always_comb begin
    w_next    = r_state;
    job_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    csr_addr  = 8'h00;
    csr_wdata = 32'h0;
    csr_wr_en = 1'b0;
    csr_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) w_next = S_WR_CFG;
      end
      S_WR_CFG: begin
        csr_wr_en = 1'b1;
        csr_addr  = c_addr_config;
        csr_wdata = {24'h0, r_job_count};
        if (csr_ready) w_next = S_WR_DIN;
      end
      S_WR_DIN: begin
        csr_wr_en = 1'b1;
        csr_addr  = c_addr_din;
        csr_wdata = r_job_data;
        if (csr_ready) w_next = S_WR_START;
      end
      S_WR_START: begin
        csr_wr_en = 1'b1;
        csr_addr  = c_addr_ctrl;
        csr_wdata = 32'h1;
        if (csr_ready) w_next = S_POLL;
      end
      S_POLL: begin
        csr_rd_en = 1'b1;
        csr_addr  = c_addr_status;
        if (csr_ready) begin
          if (w_poll_err || w_poll_timeout) w_next = S_RCV_CTRL;
          else if (w_poll_done)             w_next = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        csr_rd_en = 1'b1;
        csr_addr  = c_addr_dout;
        if (csr_ready) w_next = S_RESP;
      end
      S_RCV_CTRL: begin
        csr_wr_en = 1'b1;
        csr_addr  = c_addr_ctrl;
        csr_wdata = 32'h2;
        if (csr_ready) w_next = S_RCV_STS;
      end
      S_RCV_STS: begin
        csr_wr_en = 1'b1;
        csr_addr  = c_addr_status;
        csr_wdata = 32'h0;
        if (csr_ready) w_next = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Job latches, poll bookkeeping and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_job_data    <= 32'h0;
      r_job_count   <= 8'h0;
      r_poll_cnt    <= '0;
      r_seen_busy   <= 1'b0;
      r_last_status <= 32'h0;
      r_res_data    <= 32'h0;
      r_res_status  <= c_res_ok;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_job_data  <= job_data;
            r_job_count <= job_count;
            r_poll_cnt  <= '0;
            r_seen_busy <= 1'b0;
          end
        end
        S_POLL: begin
          if (csr_ready) begin
            r_poll_cnt    <= w_poll_inc;
            r_last_status <= csr_rdata;
            if (w_poll_err) begin
              r_res_status <= c_res_err;
            end else begin
              if (csr_rdata[1]) r_seen_busy <= 1'b1;
              if (w_poll_timeout) r_res_status <= c_res_timeout;
            end
          end
        end
        S_RD_OUT: begin
          if (csr_ready) begin
            r_res_data   <= csr_rdata;
            r_res_status <= c_res_ok;
          end
        end
        S_RCV_STS: begin
          if (csr_ready) r_res_data <= r_last_status;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_job_sequencer
// Purpose  : Self-checking bench for csr_job_sequencer with a behavioural
//            engine/bus responder and a job-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_job_sequencer;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_data;
  logic [7:0]  job_count;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_status;
  logic        busy;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr_en;
  logic        csr_rd_en;
  logic [31:0] csr_rdata;
  logic        csr_ready;

  csr_job_sequencer #(.POLL_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_data   (job_data),
    .job_count  (job_count),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_status (res_status),
    .busy       (busy),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_wr_en  (csr_wr_en),
    .csr_rd_en  (csr_rd_en),
    .csr_rdata  (csr_rdata),
    .csr_ready  (csr_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- engine / bus responder ----------------
  logic [31:0] stim_q[$];   // scripted STATUS words for the next job
  logic [31:0] rsp_q[$];    // copy consumed by the responder
  logic [31:0] dflt;        // STATUS once the script is exhausted
  logic [40:0] logq[$];     // completed accesses {wr, addr, data}
  int          logc[$];     // cycle of each completed access
  logic [40:0] expq[$];
  int          stall_left = 0;
  logic [7:0]  stall_addr = 8'h0C;
  bit          rand_stall = 0;
  int          din_cycles = 0;
  logic [31:0] eng_cfg = 0, eng_din = 0;
  bit          h_act = 0;
  logic [7:0]  h_addr;
  logic [31:0] h_wdata;
  logic [1:0]  h_strb;

  always @(negedge clk) begin
    logic rdy;
    logic [31:0] rd;
    logic strb;
    strb = csr_wr_en || csr_rd_en;
    if (strb) chk("strobe_exclusive", {31'h0, csr_wr_en && csr_rd_en}, 32'h0);
    if (h_act && reset_n) begin
      chk("stall_addr_stable", {24'h0, csr_addr}, {24'h0, h_addr});
      chk("stall_wdata_stable", csr_wdata, h_wdata);
      chk("stall_strobe_stable", {30'h0, csr_wr_en, csr_rd_en}, {30'h0, h_strb});
    end
    rdy = 1'b1;
    if (strb) begin
      if (stall_left > 0 && csr_addr == stall_addr) begin
        rdy = 1'b0;
        stall_left--;
      end else if (rand_stall && $urandom_range(0, 3) == 0) begin
        rdy = 1'b0;
      end
    end
    if (csr_wr_en && csr_addr == 8'h0C) din_cycles++;
    rd = 32'h0;
    if (csr_rd_en && csr_addr == 8'h04) rd = (rsp_q.size() > 0) ? rsp_q[0] : dflt;
    if (csr_rd_en && csr_addr == 8'h10) rd = eng_din + {24'h0, eng_cfg[7:0]};
    csr_ready = rdy;
    csr_rdata = rd;
    if (strb && rdy && reset_n) begin
      logq.push_back({csr_wr_en, csr_addr, csr_wr_en ? csr_wdata : rd});
      logc.push_back(cyc);
      if (csr_rd_en && csr_addr == 8'h04 && rsp_q.size() > 0) void'(rsp_q.pop_front());
      if (csr_wr_en && csr_addr == 8'h08) eng_cfg = csr_wdata;
      if (csr_wr_en && csr_addr == 8'h0C) eng_din = csr_wdata;
    end
    h_act   = strb && !rdy && reset_n;
    h_addr  = csr_addr;
    h_wdata = csr_wdata;
    h_strb  = {csr_wr_en, csr_rd_en};
  end

  // ---------------- job-level reference model ----------------
  task automatic model_job(input logic [31:0] data, input logic [7:0] count,
                           output logic [1:0] st, output logic [31:0] d);
    logic seen;
    logic [31:0] s;
    seen = 1'b0;
    st = 2'b11;
    d = 32'h0;
    expq.delete();
    expq.push_back({1'b1, 8'h08, {24'h0, count}});
    expq.push_back({1'b1, 8'h0C, data});
    expq.push_back({1'b1, 8'h00, 32'h1});
    for (int i = 0; i < LIMIT; i++) begin
      s = (i < stim_q.size()) ? stim_q[i] : dflt;
      expq.push_back({1'b0, 8'h04, s});
      if (s[2]) begin st = 2'b01; d = s; break; end
      if (s[1]) seen = 1'b1;
      else if (s[0] && seen) begin st = 2'b00; d = data + {24'h0, count}; break; end
      if (i == LIMIT - 1) begin st = 2'b10; d = s; break; end
    end
    if (st == 2'b00) begin
      expq.push_back({1'b0, 8'h10, d});
    end else begin
      expq.push_back({1'b1, 8'h00, 32'h2});
      expq.push_back({1'b1, 8'h04, 32'h0});
    end
  endtask

  task automatic run_job(input logic [31:0] data, input logic [7:0] count,
                         input int hold, input bit timing_chk);
    logic [1:0]  est;
    logic [31:0] ed, held;
    int acc, n, lim;
    bit jr_bad;
    model_job(data, count, est, ed);
    rsp_q = stim_q;
    logq.delete();
    logc.delete();
    din_cycles = 0;
    @(negedge clk);
    chk("job_ready_idle", {31'h0, job_ready}, 32'h1);
    job_valid = 1'b1;
    job_data  = data;
    job_count = count;
    acc = cyc;
    @(negedge clk);
    job_valid = 1'b0;
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    jr_bad = 0;
    n = 0;
    while (res_valid !== 1'b1 && n < 300) begin
      if (job_ready !== 1'b0) jr_bad = 1;
      @(negedge clk);
      n++;
    end
    chk("job_ready_low_in_job", {31'h0, jr_bad}, 32'h0);
    chk("res_valid_arrives", {31'h0, res_valid}, 32'h1);
    if (res_valid !== 1'b1) begin
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      return;
    end
    chk("res_status", {30'h0, res_status}, {30'h0, est});
    chk("res_data", res_data, ed);
    chk("bus_txn_count", logq.size(), expq.size());
    lim = (logq.size() < expq.size()) ? logq.size() : expq.size();
    for (int i = 0; i < lim; i++) begin
      chk($sformatf("bus_txn%0d_op", i), {23'h0, logq[i][40:32]}, {23'h0, expq[i][40:32]});
      chk($sformatf("bus_txn%0d_data", i), logq[i][31:0], expq[i][31:0]);
    end
    if (logc.size() > 0) chk("res_valid_latency", cyc, logc[logc.size()-1] + 1);
    if (timing_chk) begin
      chk("log_len_min", {31'h0, logc.size() >= 4}, 32'h1);
      if (logc.size() >= 4)
        for (int i = 0; i < 4; i++) chk($sformatf("txn%0d_cycle", i), logc[i], acc + 1 + i);
    end
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_res_valid", {31'h0, res_valid}, 32'h1);
      chk("hold_res_data", res_data, held);
      chk("hold_job_ready", {31'h0, job_ready}, 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drops", {31'h0, res_valid}, 32'h0);
    chk("job_ready_returns", {31'h0, job_ready}, 32'h1);
  endtask

  function automatic logic [31:0] rnd_status();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 32'h0;
    if (r < 4) return 32'h1;
    if (r < 7) return 32'h2;
    if (r == 7) return 32'h4;
    if (r == 8) return 32'h3;
    return $urandom;
  endfunction

  initial begin
    int n, len;
    reset_n   = 1'b0;
    job_valid = 1'b0;
    job_data  = 32'h0;
    job_count = 8'h0;
    res_ready = 1'b0;
    dflt      = 32'h0;
    csr_ready = 1'b1;
    csr_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", {31'h0, job_ready}, 32'h1);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_strobes", {30'h0, csr_wr_en, csr_rd_en}, 32'h0);
    chk("rst_addr", {24'h0, csr_addr}, 32'h0);
    chk("rst_wdata", csr_wdata, 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_status", {30'h0, res_status}, 32'h0);
    reset_n = 1'b1;

    // nominal job with exact cycle timing
    stim_q = '{32'h2, 32'h2, 32'h1}; dflt = 32'h0;
    run_job(32'h0000_0100, 8'd3, 0, 1);

    // DATA_IN write stalled three cycles
    stall_addr = 8'h0C; stall_left = 3;
    run_job(32'h0000_0100, 8'd3, 0, 0);
    chk("din_strobe_cycles", din_cycles, 4);

    // engine error after busy reads
    stim_q = '{32'h2, 32'h2, 32'h4};
    run_job(32'hDEAD_0000, 8'd7, 0, 0);

    // timeout: STATUS idle forever
    stim_q = {}; dflt = 32'h0;
    run_job(32'h1234_5678, 8'd1, 0, 0);

    // stale DONE ignored until BUSY has been seen
    stim_q = '{32'h1, 32'h2, 32'h1};
    run_job(32'h0000_0010, 8'd5, 0, 0);

    // consumer back-pressure for five cycles
    stim_q = '{32'h2, 32'h1};
    run_job(32'hA5A5_0000, 8'd200, 5, 0);

    // reset pulsed while polling
    stim_q = {}; dflt = 32'h2; rsp_q = {};
    @(negedge clk);
    job_valid = 1'b1; job_data = 32'h55; job_count = 8'd2;
    @(negedge clk);
    job_valid = 1'b0;
    n = 0;
    while (!(csr_rd_en === 1'b1 && csr_addr === 8'h04) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_poll", {31'h0, csr_rd_en}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rd_en", {31'h0, csr_rd_en}, 32'h0);
    chk("async_rst_wr_en", {31'h0, csr_wr_en}, 32'h0);
    chk("async_rst_job_ready", {31'h0, job_ready}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", {31'h0, res_valid}, 32'h0);
      chk("idle_after_rst", {31'h0, job_ready}, 32'h1);
    end

    // randomized jobs with random bus stalls
    rand_stall = 1;
    for (int j = 0; j < 30; j++) begin
      stim_q = {};
      len = $urandom_range(0, 9);
      for (int k = 0; k < len; k++) stim_q.push_back(rnd_status());
      case ($urandom_range(0, 2))
        0: dflt = 32'h0;
        1: dflt = 32'h1;
        default: dflt = 32'h2;
      endcase
      run_job($urandom, 8'($urandom), $urandom_range(0, 3), 0);
    end
    rand_stall = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_job_sequencer.md
# csr_job_sequencer

Bus-master sequencer that runs one processing job at a time on the CSR-mapped processing engine. It accepts a job (input word plus iteration count) over a valid/ready handshake, then programs CONFIG and DATA_IN. It pulses START, polls STATUS until DONE or ERR (with a poll timeout), reads DATA_OUT and returns the result over a second valid/ready handshake. It sits between the job source and the engine's CSR port and recovers the engine from ERR without software help.

## Interface
- POLL_LIMIT, 512: maximum STATUS reads per job before timeout (≥2).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  sequencer idle, job accepted on valid&&ready.
- job_data  in  32  word written to DATA_IN (0x0C).
- job_count  in  8  value written to CONFIG[7:0] (0x08).
- res_valid  out  1  result available.
- res_ready  in  1  result consumed on valid&&ready.
- res_data  out  32  DATA_OUT word (OK), or last STATUS word (error/timeout).
- res_status  out  2  00 OK, 01 engine ERR, 10 timeout, 11 unused.
- busy  out  1  high in every state except IDLE.
- csr_addr  out  8  engine CSR address.
- csr_wdata  out  32  write data.
- csr_wr_en  out  1  write strobe.
- csr_rd_en  out  1  read strobe.
- csr_rdata  in  32  read data, valid in the same cycle as csr_rd_en.
- csr_ready  in  1  access completes in any cycle where a strobe is high and csr_ready=1.

## Operation
- States: IDLE, WR_CFG, WR_DIN, WR_START, POLL, RD_OUT, RCV_CTRL, RCV_STS, RESP.
- CSR outputs are decoded from registered state and latches only; there is no input-to-output combinational path. wr_en and rd_en are never high together.
- A strobe with its addr/wdata is held stable until csr_ready=1; the state then advances on that edge.
- IDLE: job_ready=1. On accept, latch job_data and job_count, clear the poll counter and the seen_busy flag, then go to WR_CFG.
- WR_CFG: write 0x08 with {24'h0, count}, then go to WR_DIN.
- WR_DIN: write 0x0C with data, then go to WR_START.
- WR_START: write 0x00 with 32'h1 (START=1, IE=0), then go to POLL.
- POLL: read 0x04 every cycle. On each completed read:
  - increment the poll counter (8-bit width suffices up to 255; sized as clog2(POLL_LIMIT+1)) and store the word in last_status;
  - if bit2 (ERR) = 1, res_status←01 and go to RCV_CTRL;
  - else if bit1 (BUSY) = 1, set seen_busy;
  - else if bit0 (DONE) = 1 and seen_busy was set by an earlier read, go to RD_OUT;
  - else if the counter now equals POLL_LIMIT, res_status←10 and go to RCV_CTRL.
  - ERR has priority over DONE, DONE over timeout.
  - DONE without a prior BUSY is treated as stale from the previous job and ignored.
- RD_OUT: read 0x10, res_data←csr_rdata, res_status←00, then go to RESP.
- RCV_CTRL: write 0x00 with 32'h2 (RESET bit), then go to RCV_STS.
- RCV_STS: write 0x04 with 32'h0 (clears ERR). res_data←last_status, then go to RESP.
- RESP: res_valid=1, with res_data and res_status held stable. On res_ready, go to IDLE.
- Reset mid-job: all state clears immediately and strobes drop asynchronously. No response is issued for the abandoned job.

## Timing
- Reset values: job_ready=1; res_valid=0, busy=0, csr_wr_en=0, csr_rd_en=0; csr_addr=0, csr_wdata=0, res_data=0, res_status=0.
- With csr_ready tied high and the job accepted at edge N:
  - CONFIG write in cycle N+1, DATA_IN write in N+2, CTRL write in N+3;
  - first STATUS read in N+4;
  - DATA_OUT read one cycle after the DONE read;
  - res_valid rises the cycle after that.
- Error path: the ERR read is followed by 2 write cycles, then res_valid.
- Back-to-back jobs: job_ready rises the cycle after the res handshake; at least 1 IDLE cycle is guaranteed between jobs.
- res_valid stays high with stable data until accepted. job_ready stays 0 from accept until return to IDLE.

## Test plan
- Engine CSR block attached, csr_ready=1, job data=0x0000_0100, count=3:
  - bus sequence is wr 0x08←0x3, wr 0x0C←0x100, wr 0x00←0x1, then STATUS reads, then rd 0x10;
  - response res_data=0x0000_0103, res_status=00.
- Bus model holds csr_ready=0 for 3 cycles during the DATA_IN write: addr=0x0C, wdata and wr_en stay stable for 4 cycles, and no other strobe fires.
- Bus model returns STATUS 0x2, 0x2, then 0x4:
  - response res_status=01, res_data=0x4;
  - followed by wr 0x00←0x2 then wr 0x04←0x0.
- POLL_LIMIT=8, model returns STATUS 0x0 forever: exactly 8 reads, then the recovery writes, then res_status=10, res_data=0x0.
- Model returns STATUS 0x1 (stale DONE), then 0x2, then 0x1: completion occurs only after the third read.
- res_ready low for 5 cycles: res_valid and res_data are held and job_ready=0. Separately, reset_n pulsed low during POLL: strobes drop in the same cycle, no res_valid is issued, and job_ready=1.
